// File: rtl/cmd_resp_read.sv
// SD card CMD-line response receiver: waits for a start bit, deserialises a 48/136-bit
// response, checks CRC7, framing and Ncr timeout, and presents it in response-register layout.
`timescale 1ns / 1ps
module cmd_resp_read #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         long_resp_i,
    input  logic         check_crc_i,
    input  logic         sample_en_i,
    input  logic         cmd_ser_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] rsp_o,
    output logic [5:0]   rsp_idx_o,
    output logic         crc_err_o,
    output logic         frame_err_o,
    output logic         timeout_o
);

    localparam logic [7:0] TmoLast = 8'(TimeoutCycles - 1);

    typedef enum logic [1:0] {StIdle, StWait, StRecv, StDone} state_e;

    state_e         state_q, state_d;
    logic           long_q, long_d;
    logic           check_q, check_d;
    logic [7:0]     tmo_cnt_q, tmo_cnt_d;
    logic [7:0]     bit_idx_q, bit_idx_d;
    logic [6:0]     crc_q, crc_d;
    logic [6:0]     rx_crc_q, rx_crc_d;
    logic [127:0]   rsp_q, rsp_d;
    logic [5:0]     rsp_idx_q, rsp_idx_d;
    logic           crc_err_q, crc_err_d;
    logic           frame_err_q, frame_err_d;
    logic           timeout_q, timeout_d;

    logic [7:0]     rsp_top, crc_top, idx_base, tx_idx, off_rsp, off_idx;
    logic           crc_fb;
    logic [6:0]     crc_next;

    always_comb begin
        rsp_top  = long_q ? 8'd127 : 8'd39;
        // Short frames feed the CRC from the start bit down; the start bit itself is
        // fed on the start strobe, where a zero input on a cleared register yields zero.
        crc_top  = long_q ? 8'd127 : 8'd46;
        idx_base = long_q ? 8'd128 : 8'd40;
        tx_idx   = long_q ? 8'd134 : 8'd46;
        off_rsp  = bit_idx_q - 8'd8;
        off_idx  = bit_idx_q - idx_base;
        crc_fb   = cmd_ser_i ^ crc_q[6];
        crc_next = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
    end

    always_comb begin
        state_d     = state_q;
        long_d      = long_q;
        check_d     = check_q;
        tmo_cnt_d   = tmo_cnt_q;
        bit_idx_d   = bit_idx_q;
        crc_d       = crc_q;
        rx_crc_d    = rx_crc_q;
        rsp_d       = rsp_q;
        rsp_idx_d   = rsp_idx_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StWait;
                    long_d      = long_resp_i;
                    check_d     = check_crc_i;
                    tmo_cnt_d   = 8'd0;
                    rsp_d       = '0;
                    rsp_idx_d   = '0;
                    crc_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            StWait: begin
                if (sample_en_i) begin
                    if (!cmd_ser_i) begin
                        state_d   = StRecv;
                        bit_idx_d = long_q ? 8'd134 : 8'd46;
                        crc_d     = '0;
                        rx_crc_d  = '0;
                    end else if (tmo_cnt_q == TmoLast) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                end
            end
            StRecv: begin
                if (sample_en_i) begin
                    if (bit_idx_q >= 8'd8 && bit_idx_q <= rsp_top) begin
                        rsp_d[off_rsp[6:0]] = cmd_ser_i;
                    end
                    if (bit_idx_q >= 8'd8 && bit_idx_q <= crc_top) begin
                        crc_d = crc_next;
                    end
                    if (bit_idx_q >= idx_base && bit_idx_q < idx_base + 8'd6) begin
                        rsp_idx_d[off_idx[2:0]] = cmd_ser_i;
                    end
                    if (bit_idx_q >= 8'd1 && bit_idx_q <= 8'd7) begin
                        rx_crc_d[bit_idx_q[2:0] - 3'd1] = cmd_ser_i;
                    end
                    if (bit_idx_q == tx_idx && cmd_ser_i) begin
                        frame_err_d = 1'b1;
                    end
                    if (bit_idx_q == 8'd0) begin
                        state_d = StDone;
                        if (!cmd_ser_i) begin
                            frame_err_d = 1'b1;
                        end
                        if (check_q && rx_crc_q != crc_q) begin
                            crc_err_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q - 8'd1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            long_q      <= 1'b0;
            check_q     <= 1'b0;
            tmo_cnt_q   <= 8'd0;
            bit_idx_q   <= 8'd0;
            crc_q       <= 7'd0;
            rx_crc_q    <= 7'd0;
            rsp_q       <= '0;
            rsp_idx_q   <= 6'd0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            check_q     <= check_d;
            tmo_cnt_q   <= tmo_cnt_d;
            bit_idx_q   <= bit_idx_d;
            crc_q       <= crc_d;
            rx_crc_q    <= rx_crc_d;
            rsp_q       <= rsp_d;
            rsp_idx_q   <= rsp_idx_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy_o      = (state_q == StWait) || (state_q == StRecv);
    assign done_o      = (state_q == StDone);
    assign rsp_o       = rsp_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign crc_err_o   = crc_err_q;
    assign frame_err_o = frame_err_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cmd_resp_read.sv
// Self-checking bench for cmd_resp_read: frames are built and judged by a reference model
// based on polynomial division and direct bit-field extraction.
`timescale 1ns / 1ps
module tb_cmd_resp_read;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic         long_resp_i = 1'b0;
    logic         check_crc_i = 1'b0;
    logic         sample_en_i = 1'b0;
    logic         cmd_ser_i = 1'b1;
    logic         busy_o, done_o, crc_err_o, frame_err_o, timeout_o;
    logic [127:0] rsp_o;
    logic [5:0]   rsp_idx_o;

    int checks = 0;
    int failures = 0;

    cmd_resp_read #(.TimeoutCycles(64)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .long_resp_i (long_resp_i),
        .check_crc_i (check_crc_i),
        .sample_en_i (sample_en_i),
        .cmd_ser_i   (cmd_ser_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rsp_o       (rsp_o),
        .rsp_idx_o   (rsp_idx_o),
        .crc_err_o   (crc_err_o),
        .frame_err_o (frame_err_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Remainder of M(x)*x^7 divided by x^7+x^3+1, message = f[hi:8] (f[hi] highest degree).
    function automatic logic [6:0] crc7_ref(input logic [135:0] f, input int hi);
        logic [143:0] r;
        int n;
        r = '0;
        n = hi - 7;
        for (int i = 0; i < n; i++) r[i + 7] = f[8 + i];
        for (int i = n + 6; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] f;
        f = '0;
        f[47:0] = {2'b00, idx, arg, 7'h00, 1'b1};
        f[7:1] = crc7_ref(f, 47);
        return f;
    endfunction

    function automatic logic [135:0] mk_long(input logic [119:0] cid);
        logic [135:0] f;
        f = {2'b00, 6'h3F, cid, 7'h00, 1'b1};
        f[7:1] = crc7_ref(f, 127);
        return f;
    endfunction

    task automatic gap(input int maxgap);
        repeat ($urandom_range(0, maxgap)) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic strobe(input logic b);
        sample_en_i = 1'b1;
        cmd_ser_i   = b;
        @(posedge clk_i);
        #1;
        sample_en_i = 1'b0;
        cmd_ser_i   = 1'b1;
    endtask

    task automatic arm(input logic lng, input logic chk);
        start_i     = 1'b1;
        long_resp_i = lng;
        check_crc_i = chk;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        long_resp_i = 1'($urandom);
        check_crc_i = 1'($urandom);
    endtask

    task automatic run_frame(input string name, input logic [135:0] f, input logic lng,
                             input logic chk, input int idle, input int maxgap, input int poke);
        int           n;
        int           early;
        logic [127:0] e_rsp;
        logic [5:0]   e_idx;
        logic         e_crc, e_frm;
        n     = lng ? 136 : 48;
        early = 0;
        e_rsp = lng ? {8'h00, f[127:8]} : {96'h0, f[39:8]};
        e_idx = lng ? f[133:128] : f[45:40];
        e_frm = (f[n - 2] != 1'b0) || (f[0] != 1'b1);
        e_crc = chk && (crc7_ref(f, lng ? 127 : 47) != f[7:1]);

        arm(lng, chk);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start: busy_o=%b expected 1", name, busy_o);
        end
        repeat (idle) begin
            gap(maxgap);
            strobe(1'b1);
        end
        for (int i = n - 1; i >= 0; i--) begin
            if (i == poke) begin
                start_i     = 1'b1;
                long_resp_i = ~lng;
                check_crc_i = ~chk;
                @(posedge clk_i);
                #1;
                start_i = 1'b0;
            end
            gap(maxgap);
            strobe(f[i]);
            if (i > 0 && done_o) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL %s early_done: pulses=%0d expected 0", name, early);
        end
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("FAIL %s done_latency: done_o=%b expected 1", name, done_o);
        end
        checks++;
        if (rsp_o !== e_rsp) begin
            failures++;
            $display("FAIL %s rsp: rsp_o=%h expected %h", name, rsp_o, e_rsp);
        end
        checks++;
        if (rsp_idx_o !== e_idx) begin
            failures++;
            $display("FAIL %s idx: rsp_idx_o=%h expected %h", name, rsp_idx_o, e_idx);
        end
        checks++;
        if (crc_err_o !== e_crc) begin
            failures++;
            $display("FAIL %s crc_err: crc_err_o=%b expected %b", name, crc_err_o, e_crc);
        end
        checks++;
        if (frame_err_o !== e_frm) begin
            failures++;
            $display("FAIL %s frame_err: frame_err_o=%b expected %b", name, frame_err_o, e_frm);
        end
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL %s timeout: timeout_o=%b expected 0", name, timeout_o);
        end
        // start_i during the done cycle must be ignored
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || rsp_o !== e_rsp || crc_err_o !== e_crc) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b rsp=%h crc=%b expected 0 0 %h %b",
                     name, done_o, busy_o, rsp_o, crc_err_o, e_rsp, e_crc);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rsp_o !== '0 || rsp_idx_o !== '0 ||
            crc_err_o !== 1'b0 || frame_err_o !== 1'b0 || timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b rsp=%h idx=%h flags=%b%b%b expected all 0",
                     busy_o, done_o, rsp_o, rsp_idx_o, crc_err_o, frame_err_o, timeout_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_directed();
        logic [135:0] f;
        f = '0;
        f[47:0] = 48'h08_000001AA_13;
        run_frame("r7", f, 1'b0, 1'b1, 2, 0, -1);
        f[20] = ~f[20];
        run_frame("r7_flip20", f, 1'b0, 1'b1, 0, 1, -1);
        f = '0;
        f[47:0] = 48'h3F_80FF8000_FF;
        run_frame("r3_nocrc", f, 1'b0, 1'b0, 1, 2, -1);
    endtask

    task automatic test_timeout();
        arm(1'b0, 1'b1);
        repeat (63) begin
            gap(1);
            strobe(1'b1);
        end
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL tmo_63: done=%b busy=%b expected 0 1", done_o, busy_o);
        end
        gap(2);
        strobe(1'b1);
        checks++;
        if (done_o !== 1'b1 || timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL tmo_64: done=%b timeout=%b expected 1 1", done_o, timeout_o);
        end
        checks++;
        if (rsp_o !== '0 || rsp_idx_o !== '0 || crc_err_o !== 1'b0 || frame_err_o !== 1'b0) begin
            failures++;
            $display("FAIL tmo_payload: rsp=%h idx=%h crc=%b frm=%b expected 0", rsp_o, rsp_idx_o,
                     crc_err_o, frame_err_o);
        end
        @(posedge clk_i);
        #1;
        // start bit on the 64th strobe beats the timeout
        run_frame("start_wins", mk_short(6'($urandom), $urandom), 1'b0, 1'b1, 63, 0, -1);
    endtask

    task automatic test_frame_err_then_r2();
        logic [135:0] f;
        f = mk_short(6'd13, $urandom);
        f[0] = 1'b0;
        run_frame("r1_endbit0", f, 1'b0, 1'b1, 0, 0, -1);
        f = mk_long({$urandom, $urandom, $urandom, 24'($urandom)});
        run_frame("r2_cid", f, 1'b1, 1'b1, 3, 3, 70);
    endtask

    task automatic test_reset_midframe();
        logic [135:0] f;
        int           dn;
        dn = 0;
        f = mk_short(6'd17, $urandom);
        arm(1'b0, 1'b1);
        for (int i = 47; i > 20; i--) begin
            gap(1);
            strobe(f[i]);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rsp_o !== '0 || rsp_idx_o !== '0 ||
            crc_err_o !== 1'b0 || frame_err_o !== 1'b0 || timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: busy=%b done=%b rsp=%h idx=%h expected all 0", busy_o, done_o,
                     rsp_o, rsp_idx_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (4) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) dn++;
        end
        checks++;
        if (dn != 0) begin
            failures++;
            $display("FAIL rst_no_done: active_cycles=%0d expected 0", dn);
        end
        run_frame("r1_after_rst", mk_short(6'd55, $urandom), 1'b0, 1'b1, 0, 1, -1);
    endtask

    task automatic test_random();
        logic [135:0] f;
        logic         lng, chk;
        for (int k = 0; k < 8; k++) begin
            lng = ($urandom_range(0, 3) == 0);
            chk = 1'($urandom);
            f = lng ? mk_long({$urandom, $urandom, $urandom, 24'($urandom)})
                    : mk_short(6'($urandom), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                int b;
                b = $urandom_range(0, lng ? 134 : 46);
                f[b] = ~f[b];
            end
            run_frame("rand", f, lng, chk, $urandom_range(0, 10), $urandom_range(0, 3),
                      $urandom_range(0, 40));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_frame_err_then_r2();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
